// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: funct3/funct7 codes and FSM states.
package alu_pkg;

   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,
      F3_SLL  = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SR   = 3'b101,
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } alu_f3_e;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } md_f3_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_exec_stage_muldiv.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on magnitudes, one bit per
// cycle, with sign and divide-by-zero fix-up applied on the way out.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] res_o
);

   localparam int CW = $clog2(XLEN);

   logic            busy_q;
   logic [CW-1:0]   cnt_q;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] opnd_q, a_raw_q;
   logic [2:0]      op_q;
   logic            neg_res_q, neg_rem_q, div0_q;

   logic            sign_a, sign_b, is_div;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;

   assign is_div = op_i[2];
   assign sign_a = a_i[XLEN-1] & (op_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
   assign sign_b = b_i[XLEN-1] & (op_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
   assign mag_a  = sign_a ? -a_i : a_i;
   assign mag_b  = sign_b ? -b_i : b_i;

   // acc = {partial product | remainder, multiplier | quotient}
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = acc_q[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      if (op_q[2]) begin
         acc_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   // NOTE: only the control state is reset; datapath registers are always loaded on start
   // before they are read, so resetting them would add nothing.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= CW'(XLEN - 1);
      end else if (busy_q) begin
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == '0) busy_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start_i) begin
         acc_q     <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
         opnd_q    <= is_div ? mag_b : mag_a;
         op_q      <= op_i;
         neg_res_q <= sign_a ^ sign_b;
         neg_rem_q <= sign_a;
         div0_q    <= (b_i == '0);
         a_raw_q   <= a_i;
      end else if (busy_q) begin
         acc_q <= acc_d;
      end
   end

   // Final step happens this cycle; res_o is valid on the following cycle.
   assign done_o = busy_q && (cnt_q == '0);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;

   always_comb begin
      prod = neg_res_q ? -acc_q : acc_q;
      quo  = acc_q[XLEN-1:0];
      rem  = acc_q[2*XLEN-1:XLEN];
      if (neg_res_q) quo = -acc_q[XLEN-1:0];
      if (neg_rem_q) rem = -acc_q[2*XLEN-1:XLEN];
      case (op_q)
         F3_MUL:                        res_o = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  res_o = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:               res_o = div0_q ? '1 : quo;
         default:                       res_o = div0_q ? a_raw_q : rem;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// RV32IM execute stage: single-cycle ALU plus iterative mul/div, with a stall output that
// freezes the upstream decode latch while a multi-cycle op is in flight.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit M_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [9:0]      aluCtrl,
   input  logic            imm_en,
   input  logic [31:0]     imm,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            stall,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   logic [6:0]      f7;
   logic [2:0]      f3;
   logic [XLEN-1:0] opb, alu_res;
   logic            is_mop, is_sub, is_sra;

   assign f7     = aluCtrl[9:3];
   assign f3     = aluCtrl[2:0];
   assign opb    = imm_en ? imm : rs2;
   assign is_mop = (f7 == F7_MULDIV) && !imm_en;
   // Immediate forms have no SUB; only the shift-right variant reads funct7.
   assign is_sub = !imm_en && f7[5];
   assign is_sra = f7[5];

   always_comb begin
      case (f3)
         F3_ADD:  alu_res = is_sub ? rs1 - opb : rs1 + opb;
         F3_SLL:  alu_res = rs1 << opb[4:0];
         F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(opb)};
         F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1 < opb};
         F3_XOR:  alu_res = rs1 ^ opb;
         F3_SR:   alu_res = is_sra ? XLEN'($signed(rs1) >>> opb[4:0]) : rs1 >> opb[4:0];
         F3_OR:   alu_res = rs1 | opb;
         default: alu_res = rs1 & opb;
      endcase
   end

   logic            md_start, md_done;
   logic [XLEN-1:0] md_res;

   muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk     (clk),
      .reset   (reset),
      .start_i (md_start),
      .op_i    (f3),
      .a_i     (rs1),
      .b_i     (opb),
      .done_o  (md_done),
      .res_o   (md_res)
   );

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            result_valid_q, result_valid_d;

   // NOTE: every output of this block gets a default first so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d        = state_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      stall          = 1'b0;
      md_start       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_mop && M_EN) begin
                  md_start = 1'b1;
                  stall    = 1'b1;
                  state_d  = ST_BUSY;
               end else begin
                  result_d       = is_mop ? '0 : alu_res;
                  result_valid_d = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (md_done) state_d = ST_DONE;
         end
         default: begin
            result_d       = md_res;
            result_valid_d = 1'b1;
            state_d        = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule
